// File: rtl/i2s_transmitter_pkg.sv
// Shared audio definitions for the I2S transmit and receive paths:
// LR polarity, default frame geometry, the stereo pair type and LR edge classification.
`timescale 1ns/1ps
package i2s_transmitter_pkg;

  localparam int DEFAULT_WORD_SIZE = 16;
  localparam int DEFAULT_SLOT_SIZE = 32;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  typedef struct packed {
    logic [DEFAULT_WORD_SIZE-1:0] left;
    logic [DEFAULT_WORD_SIZE-1:0] right;
  } stereo_pair_t;

  typedef enum logic [1:0] {
    LR_EDGE_NONE,
    LR_EDGE_LEFT,
    LR_EDGE_RIGHT
  } lr_edge_e;

  // A change of word select marks the start of the channel it now selects.
  function automatic lr_edge_e classify_lr_edge(input logic old_lr, input logic lr);
    if (old_lr == LR_RIGHT && lr == LR_LEFT) begin
      return LR_EDGE_LEFT;
    end
    if (old_lr == LR_LEFT && lr == LR_RIGHT) begin
      return LR_EDGE_RIGHT;
    end
    return LR_EDGE_NONE;
  endfunction

endpackage

// File: rtl/i2s_pair_fifo.sv
// Two-entry stereo-pair FIFO between the sample producer and the frame serializer.
`timescale 1ns/1ps
module i2s_pair_fifo
  import i2s_transmitter_pkg::*;
#(
  parameter int wordSize = DEFAULT_WORD_SIZE
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [wordSize-1:0] push_left_i,
  input  logic [wordSize-1:0] push_right_i,
  input  logic                pop_i,
  output logic [wordSize-1:0] head_left_o,
  output logic [wordSize-1:0] head_right_o,
  output logic [1:0]          count_o
);

  logic [2*wordSize-1:0] mem_q [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  push_ok;
  logic                  pop_ok;

  // A push into a full FIFO is dropped even alongside a pop; the producer is gated by count anyway.
  assign push_ok = push_i && (count_q != 2'd2);
  assign pop_ok  = pop_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= {push_left_i, push_right_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign {head_left_o, head_right_o} = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S slave transmitter: serialises buffered stereo pairs MSB first, framed by the codec's
// LR clock, sending silence and reporting an underrun when a frame starts with no data.
`timescale 1ns/1ps
module i2s_transmitter
  import i2s_transmitter_pkg::*;
#(
  parameter int wordSize   = DEFAULT_WORD_SIZE,
  parameter int slotSize   = DEFAULT_SLOT_SIZE,
  parameter int countWidth = 8
) (
  input  logic                  codecBitClock,
  input  logic                  rst,
  input  logic                  codecLRClock,
  input  logic [wordSize-1:0]   inDataLeft,
  input  logic [wordSize-1:0]   inDataRight,
  input  logic                  inValid,
  output logic                  inReady,
  output logic                  codecData,
  output logic                  frameStart,
  output logic                  underrun,
  output logic [countWidth-1:0] underrunCount
);

  localparam int BitCntW = $clog2(wordSize + 1);
  localparam logic [BitCntW-1:0] WordLen = BitCntW'(wordSize);

  generate
    if (slotSize < wordSize + 1) begin : g_slot_check
      $error("slotSize must be at least wordSize+1");
    end
  endgenerate

  logic                  old_lr_q;
  logic                  synced_q,      synced_d;
  logic [wordSize-1:0]   shift_q,       shift_d;
  logic [wordSize-1:0]   right_hold_q,  right_hold_d;
  logic [BitCntW-1:0]    bit_cnt_q,     bit_cnt_d;
  logic                  data_q,        data_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q,    underrun_d;
  logic [countWidth-1:0] ucount_q,      ucount_d;

  logic [1:0]            fifo_count;
  logic [wordSize-1:0]   head_left;
  logic [wordSize-1:0]   head_right;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic [wordSize-1:0]   load_word;
  lr_edge_e              lr_edge;

  assign inReady = (fifo_count < 2'd2);
  assign push    = inValid && inReady;
  assign lr_edge = classify_lr_edge(old_lr_q, codecLRClock);

  i2s_pair_fifo #(
    .wordSize(wordSize)
  ) u_fifo (
    .clk_i       (codecBitClock),
    .rst_i       (rst),
    .push_i      (push),
    .push_left_i (inDataLeft),
    .push_right_i(inDataRight),
    .pop_i       (pop),
    .head_left_o (head_left),
    .head_right_o(head_right),
    .count_o     (fifo_count)
  );

  always_comb begin
    synced_d      = synced_q;
    shift_d       = shift_q;
    right_hold_d  = right_hold_q;
    bit_cnt_d     = bit_cnt_q;
    data_d        = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    ucount_d      = ucount_q;
    pop           = 1'b0;
    load          = 1'b0;
    load_word     = '0;

    unique case (lr_edge)
      LR_EDGE_LEFT: begin
        synced_d      = 1'b1;
        frame_start_d = 1'b1;
        load          = 1'b1;
        if (fifo_count != 2'd0) begin
          pop          = 1'b1;
          load_word    = head_left;
          right_hold_d = head_right;
        end else begin
          right_hold_d = '0;
          underrun_d   = 1'b1;
          if (ucount_q != '1) begin
            ucount_d = ucount_q + countWidth'(1);
          end
        end
      end
      LR_EDGE_RIGHT: begin
        // Until a left start has been seen the held right word is meaningless.
        load      = 1'b1;
        load_word = synced_q ? right_hold_q : '0;
      end
      default: begin
        if (bit_cnt_q < WordLen) begin
          data_d    = shift_q[wordSize-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
    endcase

    // The MSB leaves on the edge that detects the LR change, so the shifter keeps the rest.
    if (load) begin
      data_d    = load_word[wordSize-1];
      shift_d   = load_word << 1;
      bit_cnt_d = BitCntW'(1);
    end
  end

  always_ff @(posedge codecBitClock or posedge rst) begin
    if (rst) begin
      old_lr_q      <= codecLRClock;
      synced_q      <= 1'b0;
      shift_q       <= '0;
      right_hold_q  <= '0;
      bit_cnt_q     <= '0;
      data_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      ucount_q      <= '0;
    end else begin
      old_lr_q      <= codecLRClock;
      synced_q      <= synced_d;
      shift_q       <= shift_d;
      right_hold_q  <= right_hold_d;
      bit_cnt_q     <= bit_cnt_d;
      data_q        <= data_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      ucount_q      <= ucount_d;
    end
  end

  assign codecData     = data_q;
  assign frameStart    = frame_start_q;
  assign underrun      = underrun_q;
  assign underrunCount = ucount_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: a frame-level reference model checked every cycle,
// plus directed frames whose captured words are compared against literal values.
`timescale 1ns/1ps
module tb_i2s_transmitter;

  localparam int W    = 16;
  localparam int SLOT = 32;
  localparam int CW   = 8;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          lr;
  logic [W-1:0]  in_l;
  logic [W-1:0]  in_r;
  logic          in_valid;
  logic          in_ready;
  logic          codec_data;
  logic          frame_start;
  logic          underrun;
  logic [CW-1:0] underrun_count;

  i2s_transmitter #(
    .wordSize  (W),
    .slotSize  (SLOT),
    .countWidth(CW)
  ) dut (
    .codecBitClock(clk),
    .rst          (rst),
    .codecLRClock (lr),
    .inDataLeft   (in_l),
    .inDataRight  (in_r),
    .inValid      (in_valid),
    .inReady      (in_ready),
    .codecData    (codec_data),
    .frameStart   (frame_start),
    .underrun     (underrun),
    .underrunCount(underrun_count)
  );

  always #5 clk = ~clk;

  initial assert (SLOT >= W + 1);

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int fs_seen = 0;
  bit saw_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each LR change starts a word; bit j after the change is word[W-1-j].
  pair_t         mq[$];
  pair_t         acc_log[$];
  logic          m_prev_lr;
  logic          m_synced;
  logic [W-1:0]  m_cur;
  logic [W-1:0]  m_rhold;
  int            m_j;
  int            m_sz;
  logic          e_data, e_fs, e_ur, e_rdy;
  logic [CW-1:0] e_cnt;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_prev_lr = lr;
        m_synced  = 1'b0;
        m_cur     = '0;
        m_rhold   = '0;
        m_j       = W;
        e_data    = 1'b0;
        e_fs      = 1'b0;
        e_ur      = 1'b0;
        e_cnt     = '0;
        mq.delete();
        e_rdy     = 1'b1;
      end else begin
        m_sz = mq.size();
        e_fs = 1'b0;
        e_ur = 1'b0;
        if (m_prev_lr == 1'b1 && lr == 1'b0) begin
          m_synced = 1'b1;
          m_j      = 0;
          e_fs     = 1'b1;
          if (m_sz > 0) begin
            pair_t p;
            p       = mq.pop_front();
            m_cur   = p.l;
            m_rhold = p.r;
          end else begin
            m_cur   = '0;
            m_rhold = '0;
            e_ur    = 1'b1;
            if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
          end
        end else if (m_prev_lr == 1'b0 && lr == 1'b1) begin
          m_j   = 0;
          m_cur = m_synced ? m_rhold : '0;
        end else if (m_j < W) begin
          m_j = m_j + 1;
        end
        e_data = (m_j < W) ? m_cur[W-1-m_j] : 1'b0;
        if (in_valid && m_sz < 2) begin
          pair_t np;
          np.l = in_l;
          np.r = in_r;
          mq.push_back(np);
          acc_log.push_back(np);
        end
        e_rdy     = (mq.size() < 2);
        m_prev_lr = lr;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("codecData", 32'(codec_data), 32'(e_data));
        chk("frameStart", 32'(frame_start), 32'(e_fs));
        chk("underrun", 32'(underrun), 32'(e_ur));
        chk("underrunCount", 32'(underrun_count), 32'(e_cnt));
        chk("inReady", 32'(in_ready), 32'(e_rdy));
      end
    end
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    #2 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_codecData", 32'(codec_data), 32'd0);
    chk("rst_frameStart", 32'(frame_start), 32'd0);
    chk("rst_underrunCount", 32'(underrun_count), 32'd0);
    chk("rst_inReady", 32'(in_ready), 32'd1);
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_pair(input logic [W-1:0] l, input logic [W-1:0] r);
    in_valid = 1'b1;
    in_l     = l;
    in_r     = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Hold LR at v for n edges, capturing up to W transmitted bits; mode selects producer activity.
  task automatic slot(input logic v, input int n, input int mode, output logic [W-1:0] word);
    lr   = v;
    word = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i < W) word = {word[W-2:0], codec_data};
      if (frame_start === 1'b1) fs_seen++;
      if (in_ready === 1'b0) saw_full = 1'b1;
      case (mode)
        1: begin
          in_valid = 1'b1;
          in_l     = W'($urandom);
          in_r     = W'($urandom);
        end
        2: begin
          in_valid = 1'($urandom_range(0, 1));
          in_l     = W'($urandom);
          in_r     = W'($urandom);
        end
        default: in_valid = 1'b0;
      endcase
    end
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] wr;
    logic [W-1:0] top10;
    pair_t        p;

    rst      = 1'b0;
    lr       = 1'b1;
    in_valid = 1'b0;
    in_l     = '0;
    in_r     = '0;
    #3;

    // Single pair, 32/32 frame.
    do_reset(2);
    push_pair(16'hA5F0, 16'h0F0F);
    fs_seen = 0;
    slot(1'b0, SLOT, 0, w);
    chk("t1_left_word", 32'(w), 32'h0000A5F0);
    chk("t1_frameStart_count", 32'(fs_seen), 32'd1);
    slot(1'b1, SLOT, 0, w);
    chk("t1_right_word", 32'(w), 32'h00000F0F);
    chk("t1_no_underrun", 32'(underrun_count), 32'd0);

    // Empty buffer at a left start.
    slot(1'b0, SLOT, 0, w);
    chk("t2_silent_left", 32'(w), 32'd0);
    chk("t2_underrun_count", 32'(underrun_count), 32'd1);
    slot(1'b1, SLOT, 0, w);
    chk("t2_silent_right", 32'(w), 32'd0);

    // Saturation of the underrun counter.
    for (int k = 0; k < 300; k++) begin
      slot(1'b0, W + 1, 0, w);
      slot(1'b1, W + 1, 0, w);
    end
    chk("t3_underrun_saturated", 32'(underrun_count), 32'h000000FF);

    // Push at the same edge as a pop with one pair buffered.
    push_pair(16'h1357, 16'h2468);
    in_valid = 1'b1;
    in_l     = 16'hBEEF;
    in_r     = 16'hCAFE;
    slot(1'b0, SLOT, 0, w);
    chk("t4_first_left", 32'(w), 32'h00001357);
    chk("t4_ready_after_swap", 32'(in_ready), 32'd1);
    slot(1'b1, SLOT, 0, w);
    chk("t4_first_right", 32'(w), 32'h00002468);
    slot(1'b0, SLOT, 0, w);
    chk("t4_second_left", 32'(w), 32'h0000BEEF);
    slot(1'b1, SLOT, 0, w);
    chk("t4_second_right", 32'(w), 32'h0000CAFE);

    // Reset in the middle of a left word.
    push_pair(16'hFFFF, 16'h1234);
    slot(1'b0, 5, 0, w);
    chk("t5_bits_before_reset", 32'(w), 32'h0000001F);
    do_reset(3);
    slot(1'b0, 10, 0, w);
    chk("t5_left_tail_after_reset", 32'(w), 32'd0);
    slot(1'b1, SLOT, 0, w);
    chk("t5_right_after_reset", 32'(w), 32'd0);
    chk("t5_no_underrun_unsynced", 32'(underrun_count), 32'd0);
    push_pair(16'hC3A5, 16'h5A3C);
    slot(1'b0, SLOT, 0, w);
    chk("t5_resume_left", 32'(w), 32'h0000C3A5);
    slot(1'b1, SLOT, 0, w);
    chk("t5_resume_right", 32'(w), 32'h00005A3C);

    // Minimum-length slots and a truncated slot.
    push_pair(16'h8001, 16'h7FFE);
    push_pair(16'hDEAD, 16'hB00C);
    slot(1'b0, W + 1, 0, w);
    chk("t6_min_left", 32'(w), 32'h00008001);
    slot(1'b1, W + 1, 0, w);
    chk("t6_min_right", 32'(w), 32'h00007FFE);
    slot(1'b0, 10, 0, w);
    wr    = 16'hDEAD;
    top10 = wr >> 6;
    chk("t6_truncated_left", 32'(w), 32'(top10));
    slot(1'b1, W + 1, 0, w);
    chk("t6_after_truncation_right", 32'(w), 32'h0000B00C);

    // Streaming loopback with an always-valid producer.
    lr = 1'b1;
    do_reset(2);
    acc_log.delete();
    saw_full = 1'b0;
    slot(1'b1, 4, 1, w);
    for (int k = 0; k < 64; k++) begin
      slot(1'b0, SLOT, 1, w);
      slot(1'b1, SLOT, 1, wr);
      if (acc_log.size() == 0) begin
        chk("t7_pair_available", 32'd0, 32'd1);
      end else begin
        p = acc_log.pop_front();
        chk("t7_stream_left", 32'(w), 32'(p.l));
        chk("t7_stream_right", 32'(wr), 32'(p.r));
      end
    end
    chk("t7_no_underrun", 32'(underrun_count), 32'd0);
    chk("t7_ready_throttled", 32'(saw_full), 32'd1);

    // Random producer and random slot lengths, including truncated slots.
    for (int k = 0; k < 40; k++) begin
      slot(1'b0, $urandom_range(W + 1, 40), 2, w);
      slot(1'b1, $urandom_range(W + 1, 40), 2, w);
    end
    for (int k = 0; k < 20; k++) begin
      slot(1'b0, $urandom_range(3, 40), 2, w);
      slot(1'b1, $urandom_range(3, 40), 2, w);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises stereo PCM samples onto the I2S data line for the DAC path; it is the transmit counterpart of the audio receive path.
- Slave timing: the codec supplies the bit clock and the LR clock, and this block drives only the data line.
- A 2-entry stereo-pair buffer decouples the producer (visualizer/test tone logic, same clock domain) from frame timing.
- If the buffer is empty when a frame starts, silence is sent and the underrun is reported.

Parameters:
- wordSize, 16, bits per channel sample, sent MSB first.
- slotSize, 32, bit clocks per channel half-frame; must be >= wordSize+1.
- countWidth, 8, width of the saturating underrun counter.

Ports:
- codecBitClock  in  1  sole clock. Integration connects it so that its rising edge is the codec BCLK falling edge (launch edge).
- rst  in  1  asynchronous active-high reset.
- codecLRClock  in  1  codec word select; 0 = left, 1 = right.
- inDataLeft  in  wordSize  left sample of the offered pair.
- inDataRight  in  wordSize  right sample of the offered pair.
- inValid  in  1  producer offers a pair.
- inReady  out  1  buffer can accept a pair; equals (count < 2), combinational from registered count.
- codecData  out  1  serial data to the codec.
- frameStart  out  1  one-cycle pulse when a left word starts being transmitted.
- underrun  out  1  one-cycle pulse when a frame starts with the buffer empty.
- underrunCount  out  countWidth  saturating count of underruns.

Behaviour:
- Reset values: codecData=0, frameStart=0, underrun=0, underrunCount=0, buffer count=0, shift register=0, bit counter=0, synced=0, oldLR <= codecLRClock.
- Reset is honoured mid-frame.
- Push: a pair is written when inValid && inReady at an edge. Pairs are consumed in FIFO order.
- Every edge: oldLR <= codecLRClock. An edge is detected when codecLRClock != oldLR; it is the first launch edge after the codec's one-bit I2S delay slot.
- Left start (oldLR=1, LR=0):
  - synced <= 1.
  - If count>0: pop the head pair, load its left word into the shift register, hold its right word in rightHold, pulse frameStart.
  - If count==0: load zeros into the shift register and rightHold, pulse frameStart and underrun, increment underrunCount (saturate at all-ones).
  - codecData <= MSB of the loaded word in this same cycle; bit counter = 1.
- Right start (oldLR=0, LR=1):
  - If synced: load rightHold and drive its MSB.
  - If not synced: load zeros.
  - No pop and no underrun on a right start.
- Otherwise, while bit counter < wordSize: codecData <= next bit (MSB→LSB), counter increments.
- After wordSize bits: codecData=0 for the remainder of the slot. The counter saturates at wordSize and does not wrap.
- Latency: the MSB appears on the first launch edge after the LR transition edge, i.e. one BCLK after the LR change, per I2S.
- Simultaneous push and pop: allowed when count==1 (count stays 1; the new pair lands behind the popped pair). When count==2, inReady=0, so only the pop occurs.
- Short slot: an LR edge arriving before wordSize bits are sent truncates the word and the new word starts immediately. No error is flagged.
- Before the first left start after reset: codecData=0 and no underrun is counted.
- slotSize is used only by the bench and by the assertion slotSize >= wordSize+1; the RTL tracks the frame from codecLRClock edges, not from a slot counter.

Decomposition:
- Shared audio package: the stereo pair type (left, right words), the LR polarity constants (LEFT=0, RIGHT=1), and the default wordSize/slotSize, shared with the receiver.
- One sub-module: i2s_pair_fifo, a 2-deep stereo-pair FIFO with count, push/pop, and async reset.
- The serializer, LR edge detect, and underrun logic stay in i2s_transmitter.

Test Plan:
- Reset then push (L=16'hA5F0, R=16'h0F0F), run 32/32 frames → codecData carries A5F0 MSB first, starting one BCLK after LR falls, then 16 zeros; 0F0F after LR rises; frameStart pulses once.
- Receiver loopback: transmitter → i2s receiver with a shared LR; stream 64 random pairs with the producer always valid → identical pairs out, underrunCount=0, inReady throttles at count=2.
- Empty buffer at a left start → 32 zero bits per channel, underrun pulse, underrunCount increments by 1. Force 300 underruns → counter holds 8'hFF.
- Push at the same edge as a pop with count==1 → count stays 1, and the next frame sends the newly pushed pair.
- Assert rst mid-left-word → codecData=0 immediately; the right slot after reset is zeros with no underrun; data resumes on the next LR 1→0.
- 17-BCLK slots (wordSize+1) and a truncated 10-BCLK slot → full words in the 17-BCLK slots, top 10 bits only in the truncated slot; the next word starts cleanly.
